// File: rtl/exmem_skid_stage_if.sv
// rtl/exmem_skid_stage_if.sv - EX->MEM handshake bundle: upstream entry in, downstream entry out
interface exmem_skid_stage_if #(
  parameter int DATA_W = 197,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/exmem_skid_stage.sv
// rtl/exmem_skid_stage.sv - EX/MEM pipeline register with one-entry skid buffer; optional stats via EXMEM_STAGE_STATS_EN
module exmem_skid_stage #(
  parameter int DATA_W = 197,
  parameter int CTRL_W = 5
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     FLUSH,
`ifdef EXMEM_STAGE_STATS_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              bubble_cnt,
`endif
  exmem_skid_stage_if.slave        bus
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t            state, state_nxt;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic              in_xfer, out_xfer;

  logic              out_valid_q;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  assign in_xfer       = bus.in_valid && in_ready_q;
  assign out_xfer      = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt    = BUSY;
          load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt      = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over any transfer in the same cycle.
    if (FLUSH) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt != EMPTY);
      in_ready_q  <= (state_nxt != FULL);
      if (load_main_in) begin
        main_ctrl_q <= bus.in_ctrl;
        main_data_q <= bus.in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end else if (state_nxt == EMPTY) begin
        // Bubbles carry zero control so MEM never sees a stale write enable.
        main_ctrl_q <= '0;
      end
      if (load_skid) begin
        skid_ctrl_q <= bus.in_ctrl;
        skid_data_q <= bus.in_data;
      end
    end
  end

`ifdef EXMEM_STAGE_STATS_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid_q && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid_q && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exmem_skid_stage.sv
// tb/tb_exmem_skid_stage.sv - self-checking bench for exmem_skid_stage: vector table, corner sequences, random stream vs queue model
module tb_exmem_skid_stage;
  localparam int DATA_W = 197;
  localparam int CTRL_W = 5;
  localparam int EW     = CTRL_W + DATA_W;
  localparam int NV     = 14;

  logic CLOCK = 1'b0;
  logic RESET;
  logic FLUSH;
`ifdef EXMEM_STAGE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  exmem_skid_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  exmem_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .FLUSH      (FLUSH),
`ifdef EXMEM_STAGE_STATS_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .bus        (bus.master)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic              iv;
    logic [CTRL_W-1:0] ictrl;
    logic [DATA_W-1:0] idata;
    logic              ordy;
    logic              flush;
    logic              e_ov;
    logic              e_ir;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] mq   [$];
  logic [EW-1:0] sent [$];
  logic [EW-1:0] recv [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Occupancy-queue view of the stage: up to two entries, head is what MEM sees.
  task automatic tick();
    logic m_ir, m_ov;
    if (!RESET && !FLUSH && bus.out_valid && bus.out_ready)
      recv.push_back({bus.out_ctrl, bus.out_data});
    m_ir = (mq.size() < 2);
    m_ov = (mq.size() > 0);
    if (RESET || FLUSH) begin
      mq.delete();
    end else begin
      if (m_ov && bus.out_ready) void'(mq.pop_front());
      if (bus.in_valid && m_ir) begin
        mq.push_back({bus.in_ctrl, bus.in_data});
        sent.push_back({bus.in_ctrl, bus.in_data});
      end
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [EW-1:0] head;
    check({tag, ".out_valid"}, 256'(bus.out_valid), 256'(mq.size() > 0));
    check({tag, ".in_ready"},  256'(bus.in_ready),  256'(mq.size() < 2));
    if (mq.size() > 0) begin
      head = mq[0];
      check({tag, ".out_ctrl"}, 256'(bus.out_ctrl), 256'(head[EW-1:DATA_W]));
      check({tag, ".out_data"}, 256'(bus.out_data), 256'(head[DATA_W-1:0]));
    end else begin
      check({tag, ".out_ctrl_bubble"}, 256'(bus.out_ctrl), 256'(0));
    end
  endtask

  task automatic set_in(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    int cyc;

    vecs[0]  = '{1'b1, 5'b01010, 197'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 5'b01010, 197'h1234};
    vecs[1]  = '{1'b0, 5'b00000, 197'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 197'h0};
    vecs[2]  = '{1'b1, 5'b00011, 197'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00011, 197'hAAAA};
    vecs[3]  = '{1'b1, 5'b10100, 197'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00011, 197'hAAAA};
    vecs[4]  = '{1'b1, 5'b11001, 197'hCCCC, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00011, 197'hAAAA};
    vecs[5]  = '{1'b0, 5'b00000, 197'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'b10100, 197'hBBBB};
    vecs[6]  = '{1'b0, 5'b00000, 197'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 197'h0};
    vecs[7]  = '{1'b1, 5'b00001, 197'hDDDD, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00001, 197'hDDDD};
    vecs[8]  = '{1'b1, 5'b00110, 197'hEEEE, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 197'hDDDD};
    vecs[9]  = '{1'b1, 5'b11111, 197'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 197'h0};
    vecs[10] = '{1'b0, 5'b00000, 197'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 197'h0};
    vecs[11] = '{1'b1, 5'b01111, 197'h1111, 1'b1, 1'b0, 1'b1, 1'b1, 5'b01111, 197'h1111};
    vecs[12] = '{1'b1, 5'b11000, 197'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11000, 197'h2222};
    vecs[13] = '{1'b0, 5'b00000, 197'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 197'h0};

    RESET = 1'b1;
    FLUSH = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    RESET = 1'b0;

    check("reset.out_valid", 256'(bus.out_valid), 256'(0));
    check("reset.in_ready",  256'(bus.in_ready),  256'(1));
    check("reset.out_ctrl",  256'(bus.out_ctrl),  256'(0));
    check("reset.out_data",  256'(bus.out_data),  256'(0));

    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].iv, vecs[i].ictrl, vecs[i].idata, vecs[i].ordy);
      FLUSH = vecs[i].flush;
      tick();
      FLUSH = 1'b0;
      check($sformatf("vec%0d.out_valid", i), 256'(bus.out_valid), 256'(vecs[i].e_ov));
      check($sformatf("vec%0d.in_ready", i),  256'(bus.in_ready),  256'(vecs[i].e_ir));
      check($sformatf("vec%0d.out_ctrl", i),  256'(bus.out_ctrl),  256'(vecs[i].e_ctrl));
      if (vecs[i].e_ov)
        check($sformatf("vec%0d.out_data", i), 256'(bus.out_data), 256'(vecs[i].e_data));
    end

    // Reset while holding two entries, with a competing input/output transfer.
    set_in(1'b1, 5'b10101, 197'h5151, 1'b0);
    tick();
    set_in(1'b1, 5'b01110, 197'h6262, 1'b0);
    tick();
    check("full.in_ready", 256'(bus.in_ready), 256'(0));
    RESET = 1'b1;
    FLUSH = 1'b1;
    set_in(1'b1, 5'b11111, 197'h7373, 1'b1);
    tick();
    RESET = 1'b0;
    FLUSH = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    check("rstfull.out_valid", 256'(bus.out_valid), 256'(0));
    check("rstfull.in_ready",  256'(bus.in_ready),  256'(1));
    check("rstfull.out_ctrl",  256'(bus.out_ctrl),  256'(0));
    check("rstfull.out_data",  256'(bus.out_data),  256'(0));
`ifdef EXMEM_STAGE_STATS_EN
    check("rstfull.stall_cnt",  256'(stall_cnt),  256'(0));
    check("rstfull.bubble_cnt", 256'(bubble_cnt), 256'(0));

    set_in(1'b1, 5'b00100, 197'h9999, 1'b0);
    tick();
    set_in(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    check("stats.stall_cnt",  256'(stall_cnt),  256'(10));
    check("stats.bubble_cnt", 256'(bubble_cnt), 256'(1));
    set_in(1'b0, '0, '0, 1'b1);
    tick();
    check_model("stats_drain");
`endif

    sent.delete();
    recv.delete();
    cyc = 0;
    while (recv.size() < 100 && cyc < 3000) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      set_in(sent.size() < 100, 5'($urandom), rd, 1'($urandom_range(0, 1)));
      tick();
      check_model($sformatf("rnd%0d", cyc));
      cyc++;
    end
    check("stream.count", 256'(recv.size()), 256'(100));
    for (int k = 0; k < 100; k++) begin
      if (k < recv.size() && k < sent.size())
        check($sformatf("stream.entry%0d", k), 256'(recv[k]), 256'(sent[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
